btn_debouncer: RTL and testbench
================================

# btn_debouncer

Pushbutton front end for the board's user inputs: synchronizes one raw, bouncing button and produces a clean debounced level plus single-shot, auto-repeat and continuous clock-enable strobes. It drives the game/score logic whose values feed the seven-segment display driver. It is the input end of the user-I/O path, where the display driver is the output end. One instance is used per button.

## Interface
- DEBOUNCE_CYCLES, 4_000_000, stable-sample count required to accept a press or release (40 ms at 100 MHz)
- HOLD_CYCLES, 50_000_000, hold time after the accepted press before auto-repeat starts
- REPEAT_CYCLES, 10_000_000, auto-repeat interval base
- CNT_W, 27, counter width; every cycle parameter must be < 2^CNT_W and ≥ 2
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high; clears everything immediately
- btn_in  in  1  raw button, asynchronous to clk, bouncing
- db  out  1  debounced button level
- scen  out  1  single-clock enable: one 1-cycle pulse per accepted press
- mcen  out  1  multi-clock enable: pulses on the press, then auto-repeats while the button is held
- ccen  out  1  continuous enable: high every cycle while the debounced press is held

## Operation
- The synchronizer is two flops, s1 then s2. The FSM sees only s2.
- One CNT_W counter, cnt. It is cleared on every state entry unless stated otherwise.
- All outputs are registered Moore decodes of the state, so they are glitch-free.
- States and their outputs:
  - INI: all outputs 0. If s2=1, go to WQ.
  - WQ (press qualify): all outputs 0. If s2=0, go to INI. Otherwise increment cnt; when cnt==DEBOUNCE_CYCLES-1, go to SCEN_ST.
  - SCEN_ST: db=scen=mcen=ccen=1 for exactly one cycle, then go to HOLD.
  - HOLD: db=ccen=1. If s2=0, go to WFR. Otherwise increment cnt; when cnt==HOLD_CYCLES-1, go to MCEN_ST.
  - MCEN_ST: db=ccen=mcen=1 for one cycle, then go to REPEAT.
  - REPEAT: db=ccen=1. If s2=0, go to WFR. Otherwise increment cnt; when cnt==REPEAT_CYCLES-1, go to MCEN_ST.
  - WFR (release qualify): db=1, ccen=0. If s2=1, go to HOLD with cnt cleared, with no new scen and no new mcen. Otherwise increment cnt; when cnt==DEBOUNCE_CYCLES-1, go to INI.
- Unused state encodings go to INI on the next edge.
- Boundary conditions:
  - A press with fewer than DEBOUNCE_CYCLES consecutive synchronized 1s produces no output activity.
  - Bounce during release never re-fires scen.
  - The counter never wraps, because every exit compare lies below 2^CNT_W.
  - If reset asserts mid-press, all outputs drop at once and no pulse is emitted.
  - If the button is still held when reset deasserts, it is treated as a fresh press: full qualify, then scen.

## Timing
- Reset values: s1=s2=0, state INI, cnt=0, db=scen=mcen=ccen=0.
- Press latency: edge 0 is the first edge that samples btn_in=1. db, scen, mcen and ccen rise after edge DEBOUNCE_CYCLES+2.
- Pulse widths: scen is exactly 1 cycle wide, and so is each mcen pulse.
- Auto-repeat spacing:
  - The first repeat mcen comes HOLD_CYCLES+1 clocks after scen.
  - Later repeats come every REPEAT_CYCLES+1 clocks.
- Release: edge r is the first edge that samples btn_in=0 with the button held.
  - ccen falls after edge r+2.
  - db falls after edge r+DEBOUNCE_CYCLES+1, provided the input stays low.
- mcen coinciding with a release: a repeat mcen whose state was entered before the release is seen still completes its 1-cycle pulse.

## Test plan
All cases use DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3.
- Clean press, then hold for 30 cycles from edge 0:
  - scen is a single pulse after edge 6.
  - mcen pulses after edges 6, 15, 19, 23 and 27.
  - db and ccen go high after edge 6.
- Glitches: btn_in high for 3 cycles, low for 1, high for 2, then low → db, scen, mcen and ccen stay 0 throughout.
- Release bounce:
  - Setup: press is accepted; then the button releases for 2 cycles, re-presses for 5 cycles, and releases cleanly.
  - Required response:
    - exactly one scen;
    - db stays 1 until the final release plus 5 edges;
    - ccen drops to 0 during each release window.
- Reset mid-hold: assert reset asynchronously between edges while in HOLD → all outputs 0 before the next edge.
- Held through reset: deassert reset with btn_in=1 → scen fires 6 edges after the first post-reset edge that samples 1.
- Back-to-back presses, each 10 cycles high then 10 cycles low → one scen per press, and no mcen repeat (the hold window is never reached).

Source files
------------

// File: rtl/btn_debouncer_if.sv
// Button front-end signal bundle: raw button in, debounced level and strobes out.
// The debouncer owns the master side; the consumer (game logic or bench) owns the slave side.
interface btn_debouncer_if;
  logic btn_in;
  logic db;
  logic scen;
  logic mcen;
  logic ccen;

  modport master (
    input  btn_in,
    output db,
    output scen,
    output mcen,
    output ccen
  );

  modport slave (
    output btn_in,
    input  db,
    input  scen,
    input  mcen,
    input  ccen
  );
endinterface

// File: rtl/btn_debouncer.sv
// Pushbutton debouncer: 2-flop synchronizer, one shared counter, Moore FSM producing a clean
// level (db), a press strobe (scen), an auto-repeat strobe (mcen) and a held enable (ccen).
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter int CNT_W           = 27
) (
  input  logic              clk,
  input  logic              reset,
  btn_debouncer_if.master   bus
);

  typedef enum logic [2:0] {
    INI     = 3'd0,
    WQ      = 3'd1,
    SCEN_ST = 3'd2,
    HOLD    = 3'd3,
    MCEN_ST = 3'd4,
    REPEAT  = 3'd5,
    WFR     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             s1_q, s2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             scen_q, scen_d;
  logic             mcen_q, mcen_d;
  logic             ccen_q, ccen_d;

  // Next-state and counter; the counter clears on every transition by default
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      INI: begin
        if (s2_q) state_d = WQ;
      end
      WQ: begin
        if (!s2_q)                state_d = INI;
        else if (cnt_q == DB_LAST) state_d = SCEN_ST;
        else                      cnt_d   = cnt_q + CNT_ONE;
      end
      SCEN_ST: state_d = HOLD;
      HOLD: begin
        if (!s2_q) begin
          // The low sample that leaves HOLD is the first of the release run
          state_d = WFR;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = MCEN_ST;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      MCEN_ST: state_d = REPEAT;
      REPEAT: begin
        if (!s2_q) begin
          state_d = WFR;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == REP_LAST) begin
          state_d = MCEN_ST;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WFR: begin
        if (s2_q)                  state_d = HOLD;
        else if (cnt_q == DB_LAST) state_d = INI;
        else                       cnt_d   = cnt_q + CNT_ONE;
      end
      default: state_d = INI;
    endcase
  end

  // Outputs are decoded from the next state so they register together with it
  always_comb begin
    db_d   = 1'b0;
    scen_d = 1'b0;
    mcen_d = 1'b0;
    ccen_d = 1'b0;
    case (state_d)
      SCEN_ST: begin db_d = 1'b1; scen_d = 1'b1; mcen_d = 1'b1; ccen_d = 1'b1; end
      HOLD:    begin db_d = 1'b1; ccen_d = 1'b1; end
      MCEN_ST: begin db_d = 1'b1; mcen_d = 1'b1; ccen_d = 1'b1; end
      REPEAT:  begin db_d = 1'b1; ccen_d = 1'b1; end
      WFR:     begin db_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= INI;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      scen_q  <= 1'b0;
      mcen_q  <= 1'b0;
      ccen_q  <= 1'b0;
    end else begin
      s1_q    <= bus.btn_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      scen_q  <= scen_d;
      mcen_q  <= mcen_d;
      ccen_q  <= ccen_d;
    end
  end

  assign bus.db   = db_q;
  assign bus.scen = scen_q;
  assign bus.mcen = mcen_q;
  assign bus.ccen = ccen_q;

endmodule

// File: tb/tb_btn_debouncer.sv
// Bench for btn_debouncer: directed scenarios plus random bouncing input, checked every
// cycle against a run-length / schedule model of the button behaviour.
module tb_btn_debouncer;
  localparam int D = 4;
  localparam int H = 8;
  localparam int R = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   scen_seen = 0;
  int   mcen_seen = 0;

  btn_debouncer_if bus ();

  btn_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R),
    .CNT_W          (6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: button seen two edges late; press accepted after D+1 consecutive
  // highs, release after D consecutive lows; strobes scheduled by absolute edge number.
  logic p1, p2;
  logic pressed, skip;
  int   ones, zeros, ek, next_mcen;
  logic e_db, e_scen, e_mcen, e_ccen;

  task automatic model_reset();
    p1 = 1'b0; p2 = 1'b0;
    pressed = 1'b0; skip = 1'b0;
    ones = 0; zeros = 0; next_mcen = 0;
    e_db = 1'b0; e_scen = 1'b0; e_mcen = 1'b0; e_ccen = 1'b0;
  endtask

  task automatic model_edge(input logic b);
    logic v;
    if (reset) begin
      model_reset();
      return;
    end
    ek++;
    v  = p2;
    p2 = p1;
    p1 = b;
    e_scen = 1'b0;
    e_mcen = 1'b0;
    if (!pressed) begin
      ones = v ? ones + 1 : 0;
      if (ones == D + 1) begin
        pressed = 1'b1; e_scen = 1'b1; e_mcen = 1'b1; skip = 1'b1;
        next_mcen = ek + H + 1; ones = 0; zeros = 0;
      end
    end else if (skip) begin
      skip = 1'b0;
    end else if (zeros > 0) begin
      if (v) begin
        zeros = 0;
        next_mcen = ek + H;
      end else begin
        zeros++;
        if (zeros == D) begin
          pressed = 1'b0; zeros = 0; ones = 0;
        end
      end
    end else begin
      if (!v) zeros = 1;
      else if (ek == next_mcen) begin
        e_mcen = 1'b1; skip = 1'b1; next_mcen = ek + 1 + R;
      end
    end
    e_db   = pressed;
    e_ccen = pressed && (zeros == 0);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: got %b, want %b at t=%0t", tag, obs, exp, $time);
      end
  endtask

  // Called at a falling edge: drive, clock, compare just after the rising edge.
  task automatic step(input logic b);
    bus.btn_in = b;
    @(posedge clk);
    model_edge(b);
    #1;
    chk("db",   bus.db,   e_db);
    chk("scen", bus.scen, e_scen);
    chk("mcen", bus.mcen, e_mcen);
    chk("ccen", bus.ccen, e_ccen);
    scen_seen += int'(bus.scen);
    mcen_seen += int'(bus.mcen);
    @(negedge clk);
  endtask

  initial begin
    int  len;
    logic lvl;
    reset      = 1'b1;
    bus.btn_in = 1'b0;
    ek         = 0;
    model_reset();
    #1;
    chk("reset_db",   bus.db,   1'b0);
    chk("reset_scen", bus.scen, 1'b0);
    chk("reset_mcen", bus.mcen, 1'b0);
    chk("reset_ccen", bus.ccen, 1'b0);
    @(negedge clk);
    step(1'b0);
    step(1'b0);
    reset = 1'b0;
    for (int j = 0; j < 3; j++) step(1'b0);

    // Clean press held 30 cycles, edge 0 being the first that samples 1
    for (int j = 0; j < 30; j++) begin
      step(1'b1);
      chk("plan_scen", bus.scen, j == 6);
      chk("plan_mcen", bus.mcen, (j == 6) || (j == 15) || (j == 19) || (j == 23) || (j == 27));
      chk("plan_db",   bus.db,   j >= 6);
      chk("plan_ccen", bus.ccen, j >= 6);
    end
    for (int j = 0; j < 12; j++) step(1'b0);

    // Short glitches never qualify
    for (int j = 0; j < 14; j++) begin
      step((j < 3) || (j == 4) || (j == 5));
      chk("glitch_quiet", bus.db | bus.scen | bus.mcen | bus.ccen, 1'b0);
    end

    // Release bounce: one scen, db held until final release + 5 edges
    scen_seen = 0;
    for (int j = 0; j < 10; j++) step(1'b1);
    step(1'b0);
    step(1'b0);
    for (int j = 0; j < 5; j++) step(1'b1);
    for (int j = 0; j < 10; j++) begin
      step(1'b0);
      chk("bounce_db",   bus.db,   j < 5);
      chk("bounce_ccen", bus.ccen, j < 2);
    end
    chk("bounce_one_scen", scen_seen == 1, 1'b1);

    // Asynchronous reset while in HOLD, button kept pressed through reset
    for (int j = 0; j < 10; j++) step(1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_db",   bus.db,   1'b0);
    chk("rst_async_scen", bus.scen, 1'b0);
    chk("rst_async_mcen", bus.mcen, 1'b0);
    chk("rst_async_ccen", bus.ccen, 1'b0);
    model_reset();
    @(negedge clk);
    for (int j = 0; j < 3; j++) step(1'b1);
    reset = 1'b0;
    for (int j = 0; j < 9; j++) begin
      step(1'b1);
      chk("rst_held_scen", bus.scen, j == 6);
    end
    for (int j = 0; j < 12; j++) step(1'b0);

    // Back-to-back presses: one scen each, no repeat mcen
    scen_seen = 0;
    mcen_seen = 0;
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 10; j++) step(1'b1);
      for (int j = 0; j < 10; j++) step(1'b0);
    end
    chk("b2b_scen_count", scen_seen == 3, 1'b1);
    chk("b2b_mcen_count", mcen_seen == 3, 1'b1);

    // Random bouncing input with occasional long holds
    lvl = 1'b0;
    for (int s = 0; s < 70; s++) begin
      lvl = ~lvl;
      if ($urandom_range(0, 5) == 0) len = $urandom_range(12, 30);
      else                           len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) step(lvl);
    end
    for (int j = 0; j < 10; j++) step(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
